// File: rtl/car_pkg.sv
// Shared definitions for the car controller: state encoding and frame timing defaults.
package car_pkg;

  typedef enum logic [2:0] {
    S_WAIT_START = 3'd0,
    S_DELAY      = 3'd1,
    S_DRAW       = 3'd2,
    S_DRAW_WAIT  = 3'd3,
    S_ERASE      = 3'd4,
    S_INCREMENT  = 3'd5,
    S_DESTROYED  = 3'd6,
    S_GAME_OVER  = 3'd7
  } state_e;

  // 50 MHz / 30 fps; also used by the datapath delay counter.
  localparam int unsigned CLKS_PER_FRAME_DEFAULT = 1666667;
  localparam int unsigned CLK_CNT_W              = 21;
  localparam int unsigned FRAME_CNT_W            = 8;

endpackage

// File: rtl/control_car_frame_pacer.sv
// Counts frame periods while enabled; step_done marks the last cycle of a full step.
module frame_pacer
  import car_pkg::*;
#(
  parameter int unsigned CLKS_PER_FRAME = CLKS_PER_FRAME_DEFAULT
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic [FRAME_CNT_W-1:0] limit,
  output logic                   step_done
);

  logic [CLK_CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   tick;

  assign tick      = (clk_cnt_q == CLK_CNT_W'(CLKS_PER_FRAME - 1));
  assign step_done = enable && tick && (frame_cnt_q == limit - FRAME_CNT_W'(1));

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    clk_cnt_d   = clk_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (!enable) begin
      clk_cnt_d   = '0;
      frame_cnt_d = '0;
    end else if (tick) begin
      clk_cnt_d   = '0;
      frame_cnt_d = step_done ? '0 : frame_cnt_q + FRAME_CNT_W'(1);
    end else begin
      clk_cnt_d   = clk_cnt_q + CLK_CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      clk_cnt_q   <= clk_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: rtl/control_car.sv
// Moore controller for one car: start, delay, draw/hold/erase/move loop, destroyed or escaped.
module control_car
  import car_pkg::*;
#(
  parameter int unsigned CLKS_PER_FRAME  = CLKS_PER_FRAME_DEFAULT,
  parameter int unsigned FRAMES_PER_STEP = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic hit,
  input  logic initial_delay_done,
  input  logic draw_done,
  input  logic erase_done,
  input  logic game_over,
  output logic wait_start,
  output logic delay,
  output logic draw_car,
  output logic draw_wait,
  output logic erase_car,
  output logic increment,
  output logic destroyed_state,
  output logic plot,
  output logic car_lost
);

  state_e state_q, state_d;
  logic   hit_pend_q, hit_pend_d;
  logic   step_done;

  frame_pacer #(
    .CLKS_PER_FRAME (CLKS_PER_FRAME)
  ) u_pacer (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (state_q == S_DRAW_WAIT),
    .limit     (FRAME_CNT_W'(FRAMES_PER_STEP)),
    .step_done (step_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WAIT_START: if (start)              state_d = S_DELAY;
      S_DELAY:      if (initial_delay_done) state_d = S_DRAW;
      S_DRAW:       if (draw_done)          state_d = S_DRAW_WAIT;
      S_DRAW_WAIT: begin
        if (game_over)               state_d = S_GAME_OVER;
        else if (hit_pend_q || hit)  state_d = S_DESTROYED;
        else if (step_done)          state_d = S_ERASE;
      end
      S_ERASE:      if (erase_done)         state_d = S_INCREMENT;
      S_INCREMENT:                          state_d = S_DRAW;
      S_DESTROYED:  if (start)              state_d = S_WAIT_START;
      S_GAME_OVER:  if (start)              state_d = S_WAIT_START;
      default:                              state_d = S_WAIT_START;
    endcase
  end

  // A hit mid-move is remembered so the move finishes before the car is destroyed.
  always_comb begin
    hit_pend_d = hit_pend_q;
    if (hit && (state_q inside {S_DRAW, S_ERASE, S_INCREMENT}))
      hit_pend_d = 1'b1;
    if (state_d inside {S_WAIT_START, S_DESTROYED, S_GAME_OVER})
      hit_pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_WAIT_START;
      hit_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hit_pend_q <= hit_pend_d;
    end
  end

  assign wait_start      = (state_q == S_WAIT_START);
  assign delay           = (state_q == S_DELAY);
  assign draw_car        = (state_q == S_DRAW);
  assign draw_wait       = (state_q == S_DRAW_WAIT);
  assign erase_car       = (state_q == S_ERASE);
  assign increment       = (state_q == S_INCREMENT);
  assign destroyed_state = (state_q == S_DESTROYED);
  assign car_lost        = (state_q == S_GAME_OVER);
  assign plot            = draw_car | erase_car;

endmodule

// File: tb/tb_control_car.sv
// Randomised scoreboard bench for control_car, plus a fast-pacing second instance.
module tb_control_car;

  localparam int CPF  = 4;
  localparam int FPS  = 2;
  localparam int STEP = CPF * FPS;

  logic clk = 1'b0;
  logic resetn;
  logic start, hit, idd, dd, ed, go;
  logic o_ws, o_dl, o_dr, o_dw, o_er, o_inc, o_des, o_plot, o_lost;

  logic s1_start, s1_idd, s1_dd, s1_ed;
  logic p1_ws, p1_dl, p1_dr, p1_dw, p1_er, p1_inc, p1_des, p1_plot, p1_lost;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_car #(.CLKS_PER_FRAME(CPF), .FRAMES_PER_STEP(FPS)) dut (
    .clk(clk), .resetn(resetn), .start(start), .hit(hit),
    .initial_delay_done(idd), .draw_done(dd), .erase_done(ed), .game_over(go),
    .wait_start(o_ws), .delay(o_dl), .draw_car(o_dr), .draw_wait(o_dw),
    .erase_car(o_er), .increment(o_inc), .destroyed_state(o_des),
    .plot(o_plot), .car_lost(o_lost)
  );

  control_car #(.CLKS_PER_FRAME(CPF), .FRAMES_PER_STEP(1)) dut1 (
    .clk(clk), .resetn(resetn), .start(s1_start), .hit(1'b0),
    .initial_delay_done(s1_idd), .draw_done(s1_dd), .erase_done(s1_ed), .game_over(1'b0),
    .wait_start(p1_ws), .delay(p1_dl), .draw_car(p1_dr), .draw_wait(p1_dw),
    .erase_car(p1_er), .increment(p1_inc), .destroyed_state(p1_des),
    .plot(p1_plot), .car_lost(p1_lost)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: car phase, pending hit and cycles spent holding on screen.
  typedef enum int {M_IDLE, M_DELAY, M_DRAW, M_HOLD, M_ERASE, M_MOVE, M_DEAD, M_LOST} phase_e;
  phase_e m_phase = M_IDLE;
  bit     m_pend  = 0;
  int     m_held  = 0;

  logic [8:0] exp_q[$];

  // {wait_start, delay, draw_car, draw_wait, erase_car, increment, destroyed, plot, car_lost}
  function automatic logic [8:0] expect_of(phase_e p);
    logic [8:0] v = '0;
    case (p)
      M_IDLE:  v[8] = 1'b1;
      M_DELAY: v[7] = 1'b1;
      M_DRAW:  begin v[6] = 1'b1; v[1] = 1'b1; end
      M_HOLD:  v[5] = 1'b1;
      M_ERASE: begin v[4] = 1'b1; v[1] = 1'b1; end
      M_MOVE:  v[3] = 1'b1;
      M_DEAD:  v[2] = 1'b1;
      M_LOST:  v[0] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_step(input bit st, h, id, d, e, g);
    case (m_phase)
      M_IDLE:  if (st) m_phase = M_DELAY;
      M_DELAY: if (id) m_phase = M_DRAW;
      M_DRAW: begin
        if (h) m_pend = 1;
        if (d) begin m_phase = M_HOLD; m_held = 0; end
      end
      M_HOLD: begin
        m_held++;
        if (g) begin m_phase = M_LOST; m_pend = 0; end
        else if (m_pend || h) begin m_phase = M_DEAD; m_pend = 0; end
        else if (m_held == STEP) m_phase = M_ERASE;
      end
      M_ERASE: begin
        if (h) m_pend = 1;
        if (e) m_phase = M_MOVE;
      end
      M_MOVE: begin
        if (h) m_pend = 1;
        m_phase = M_DRAW;
      end
      M_DEAD, M_LOST: if (st) begin m_phase = M_IDLE; m_pend = 0; end
      default: m_phase = M_IDLE;
    endcase
  endtask

  // One clock cycle of stimulus: drive just after the edge, queue the expected outputs.
  task automatic cyc(input bit rn, st, h, id, d, e, g);
    @(posedge clk);
    #1;
    resetn = rn; start = st; hit = h; idd = id; dd = d; ed = e; go = g;
    if (!rn) begin
      m_phase = M_IDLE; m_pend = 0; m_held = 0;
      exp_q.push_back(expect_of(M_IDLE));
    end else begin
      exp_q.push_back(expect_of(m_phase));
      model_step(st, h, id, d, e, g);
    end
  endtask

  task automatic drive(input bit st, h, id, d, e, g);
    cyc(1'b1, st, h, id, d, e, g);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [8:0] e;
      e = exp_q.pop_front();
      check("outputs", {o_ws, o_dl, o_dr, o_dw, o_er, o_inc, o_des, o_plot, o_lost}, 32'(e));
    end
  end

  initial begin
    int dwell, inc_run, steps, incs, budget;
    resetn = 1'b0; start = 0; hit = 0; idd = 0; dd = 0; ed = 0; go = 0;
    s1_start = 0; s1_idd = 0; s1_dd = 0; s1_ed = 0;
    #2;
    check("reset_outputs", {o_ws, o_dl, o_dr, o_dw, o_er, o_inc, o_des, o_plot, o_lost}, 32'h100);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Start, delay, first draw, full hold, erase, single-cycle move.
    drive(1, 0, 0, 0, 0, 0);
    idle(2);
    drive(0, 0, 1, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    idle(1);

    // Hit during erase: the move completes, destroyed right after the hold begins.
    drive(0, 0, 0, 1, 0, 0);
    idle(STEP);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    idle(1);
    drive(0, 0, 0, 1, 0, 0);
    idle(3);
    drive(1, 0, 0, 0, 0, 0);
    idle(1);

    // game_over and hit together while holding: escape wins.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    idle(2);
    drive(0, 1, 0, 0, 0, 1);
    idle(2);
    drive(1, 0, 0, 0, 0, 0);
    idle(2);

    // Asynchronous reset between edges while erasing.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    idle(STEP + 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("async_reset_wait_start", 32'(o_ws), 32'd1);
    check("async_reset_plot", 32'(o_plot), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    idle(4);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(499) != 0,
          $urandom_range(99) < 30, $urandom_range(99) < 5,
          $urandom_range(99) < 30, $urandom_range(99) < 40,
          $urandom_range(99) < 40, $urandom_range(99) < 3);
    end
    idle(2);
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin @(negedge clk); budget++; end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // One frame per step: ten consecutive moves on the second instance.
    @(posedge clk); #1;
    s1_start = 1;
    @(posedge clk); #1;
    s1_start = 0; s1_idd = 1; s1_dd = 1; s1_ed = 1;
    dwell = 0; inc_run = 0; steps = 0; incs = 0;
    for (int c = 0; c < 300 && incs < 10; c++) begin
      @(negedge clk);
      if (p1_dw) dwell++;
      else if (dwell != 0) begin
        check("fps1_dwell", 32'(dwell), 32'd4);
        steps++;
        dwell = 0;
      end
      if (p1_inc) begin
        inc_run++;
        if (inc_run == 1) incs++;
      end else if (inc_run != 0) begin
        check("fps1_inc_width", 32'(inc_run), 32'd1);
        inc_run = 0;
      end
    end
    @(negedge clk);
    check("fps1_inc_last_width", 32'(p1_inc), 32'd0);
    check("fps1_steps", 32'(steps), 32'd10);
    check("fps1_increments", 32'(incs), 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
